// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives an external one-bit full adder LSB first for WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub input).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c_in,
    input  logic             fa_s,
    input  logic             fa_c_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign dbg_state = state;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the final carry is the inverted borrow.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_c_in   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                fa_a    = a_sr[0];
                fa_b    = b_sr[0];
                fa_c_in = carry;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b_load;
            res_sr <= '0;
            carry  <= carry_load;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_c_out;
            cnt    <= cnt + 1'b1;
            // The final sum bit is still on fa_s, so publish the merged value directly.
            if (last_bit) begin
                sum   <= {fa_s, res_sr[WIDTH-1:1]};
                c_out <= fa_c_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural full adder attached.
// Define SERIAL_ADDER_SUB_EN for both files to exercise the subtract mode.
module tb_serial_adder_ctrl;

    localparam int W = 8;
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         fa_a;
    logic         fa_b;
    logic         fa_c_in;
    logic         fa_s;
    logic         fa_c_out;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic [1:0]   dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_c_in   (fa_c_in),
        .fa_s      (fa_s),
        .fa_c_out  (fa_c_out),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .c_out     (c_out),
        .dbg_state (dbg_state)
    );

    // Behavioural one-bit full adder
    assign fa_s     = fa_a ^ fa_b ^ fa_c_in;
    assign fa_c_out = (fa_a & fa_b) | (fa_a & fa_c_in) | (fa_b & fa_c_in);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; leaves the DUT in DONE.
    task automatic drive_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cin,
                            output logic [W-1:0] got_s, output logic got_co,
                            output int lat, output int busy_n, output bit stable);
        logic [W-1:0] s0;
        s0     = sum;
        a      = aa;
        b      = bb;
        c_in   = cin;
        start  = 1'b1;
        step();
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        c_in   = 1'($urandom);
        lat    = 1;
        busy_n = 0;
        stable = 1'b1;
        while (!done && lat < BUDGET) begin
            if (busy) busy_n++;
            if (sum !== s0) stable = 1'b0;
            step();
            lat++;
        end
        got_s  = sum;
        got_co = c_out;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #1;
        n_cmp++;
        if ({busy, done, sum, c_out, fa_a, fa_b, fa_c_in, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b fa=%b%b%b state=%0d, want all 0",
                     busy, done, sum, c_out, fa_a, fa_b, fa_c_in, dbg_state);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           bn;
        bit           st;
        logic [W-1:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [W-1:0] tb[3] = '{8'h33, 8'h01, 8'hFF};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   te[3] = '{9'h08D, 9'h100, 9'h1FF};
        for (int i = 0; i < 3; i++) begin
            drive_op(ta[i], tb[i], tc[i], s, co, lat, bn, st);
            n_cmp++;
            if ({co, s} !== te[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got c_out=%b sum=%h, want c_out=%b sum=%h",
                         i, co, s, te[i][W], te[i][W-1:0]);
            end
            n_cmp++;
            if (lat != W + 1 || bn != W) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: done at cycle %0d busy %0d cycles, want %0d and %0d",
                         i, lat, bn, W + 1, W);
            end
            n_cmp++;
            if (busy !== 1'b0 || {fa_a, fa_b, fa_c_in} !== 3'b000) begin
                n_fail++;
                $display("FAIL directed_done_outputs[%0d]: busy=%b fa=%b%b%b, want 0 000",
                         i, busy, fa_a, fa_b, fa_c_in);
            end
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b state=%0d, want 0 and IDLE", done, dbg_state);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         co;
        logic [W:0]   e;
        int           lat;
        int           bn;
        bit           st;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            exp_q.push_back((W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc));
            drive_op(ra, rb, rc, s, co, lat, bn, st);
            e = exp_q.pop_front();
            n_cmp++;
            if ({co, s} !== e || lat != W + 1 || !st) begin
                n_fail++;
                $display("FAIL random[%0d] %h+%h+%b: got %b_%h lat %0d stable %0d, want %b_%h lat %0d stable 1",
                         i, ra, rb, rc, co, s, lat, st, e[W], e[W-1:0], W + 1);
            end
            if ($urandom_range(1, 0) == 1) step();
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int cyc   = 1;
        a     = 8'h5A;
        b     = 8'h33;
        c_in  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc <= 14) begin
            if (cyc == 3) begin
                start = 1'b1;
                a     = 8'hC3;
                b     = 8'h77;
                c_in  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                n_cmp++;
                if (sum !== 8'h8D || c_out !== 1'b0 || cyc != W + 1) begin
                    n_fail++;
                    $display("FAIL ignore_start_result: got sum=%h c_out=%b at cycle %0d, want 8d 0 at %0d",
                             sum, c_out, cyc, W + 1);
                end
            end
            step();
            cyc++;
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           bn;
        bit           st;
        int           dones = 0;
        a     = 8'h5A;
        b     = 8'h33;
        c_in  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, sum, c_out, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h c_out=%b state=%0d, want all 0",
                     busy, done, sum, c_out, dbg_state);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            step();
        end
        n_cmp++;
        if (dones != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses busy=%b, want 0 and 0", dones, busy);
        end
        drive_op(8'h01, 8'h02, 1'b0, s, co, lat, bn, st);
        n_cmp++;
        if (s !== 8'h03 || co !== 1'b0 || lat != W + 1) begin
            n_fail++;
            $display("FAIL reset_then_start: got sum=%h c_out=%b lat %0d, want 03 0 lat %0d",
                     s, co, lat, W + 1);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[5];
        logic [W-1:0] ob[5];
        logic         oc[5];
        logic [W:0]   e;
        bit           idle_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            oa[i] = W'($urandom);
            ob[i] = W'($urandom);
            oc[i] = 1'($urandom);
        end
        a     = oa[0];
        b     = ob[0];
        c_in  = oc[0];
        start = 1'b1;
        step();
        a     = oa[1];
        b     = ob[1];
        c_in  = oc[1];
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < W; j++) begin
                if (!busy || done) idle_seen = 1'b1;
                step();
            end
            e = (W + 1)'(oa[k]) + (W + 1)'(ob[k]) + (W + 1)'(oc[k]);
            n_cmp++;
            if (done !== 1'b1 || {c_out, sum} !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: done=%b got %b_%h, want done=1 %b_%h",
                         k, done, c_out, sum, e[W], e[W-1:0]);
            end
            step();
            a    = oa[k + 2];
            b    = ob[k + 2];
            c_in = oc[k + 2];
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back_restart[%0d]: busy=%b, want 1", k, busy);
            end
        end
        n_cmp++;
        if (idle_seen) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got a non-RUN cycle inside an operation, want none");
        end
        start = 1'b0;
        rst   = 1'b1;
        #1;
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           bn;
        bit           st;
        logic [W-1:0] ta[2] = '{8'h10, 8'h01};
        logic [W-1:0] tb[2] = '{8'h01, 8'h02};
        logic [W:0]   te[2] = '{9'h10F, 9'h0FF};
        sub = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_op(ta[i], tb[i], 1'b0, s, co, lat, bn, st);
            n_cmp++;
            if ({co, s} !== te[i]) begin
                n_fail++;
                $display("FAIL sub[%0d]: got c_out=%b sum=%h, want c_out=%b sum=%h",
                         i, co, s, te[i][W], te[i][W-1:0]);
            end
        end
        sub = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
